pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 16-bit five-stage core. It owns the IF/ID and ID/EX valid bits and drives the write enables of the PC and pipeline registers. It inserts bubbles on load-use hazards and freezes the pipe while data memory is busy. It also flushes the two younger stages and asserts `redirect`, which selects the jump unit's target into the PC, when a taken B, a CALL or a RET reaches EX.

## Interface
Parameters:
- LU_STALL, 1, load-use stall length in cycles; legal range 1..3.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- id_instr  in  16  instruction held in IF/ID.
- ex_instr  in  16  instruction held in ID/EX.
- branch  in  1  branch condition true for the B instruction in EX, from the flag logic.
- mem_busy  in  1  data memory is not ready this cycle.
- pc_we  out  1  PC write enable.
- if_id_we  out  1  IF/ID write enable.
- id_ex_we  out  1  ID/EX write enable.
- ex_mem_we  out  1  EX/MEM write enable.
- redirect  out  1  PC mux selects the jump-unit target.
- id_valid  out  1  IF/ID holds a real instruction.
- ex_valid  out  1  ID/EX holds a real instruction.
- state  out  2  FSM state: RUN=0, STALL=1, FREEZE=2.
- stall_cnt  out  CNT_W  count of load-use stall cycles.
- flush_cnt  out  CNT_W  count of redirects.

## Operation
- Opcodes come from opcode.h and occupy bits [15:12].
- **Source registers read by the ID instruction:**
  - ADD, SUB, NAND, XOR read [7:4] and [3:0].
  - SRA, SRL, SLL read [7:4].
  - INC, SW, LHB, LLB read [11:8].
  - RET reads R15.
  - LW, B, CALL read none.
  - R0 is not exempt from comparison.
- **Load-use hazard (lu):** all of the following are true:
  - ex_valid and id_valid are both 1;
  - ex_instr is LW;
  - ex_instr[11:8] equals a source register of id_instr.
- **Control hazard (ctl):** ex_valid=1 and ex_instr is one of:
  - B with branch=1;
  - CALL;
  - RET.
- lu and ctl cannot both be true, because ex_instr cannot be LW and a control instruction at once.
- **Priority:** rst > mem_busy > ctl > lu > normal.
- **Normal (RUN):**
  - All four enables are 1 and redirect=0.
  - id_valid <= 1.
  - ex_valid <= id_valid.
- **ctl (RUN):**
  - redirect=1 and all enables are 1.
  - id_valid <= 0 and ex_valid <= 0.
  - flush_cnt increments.
  - Next state is RUN.
- **lu (RUN):**
  - pc_we=0 and if_id_we=0; id_ex_we=1 and ex_mem_we=1.
  - ex_valid <= 0 (bubble) and id_valid holds.
  - stall_cnt increments.
  - If LU_STALL>1, the remaining-stall counter is loaded with LU_STALL-1 and the FSM enters STALL.
- **STALL:**
  - Enables and valid updates are the same as for lu.
  - stall_cnt increments and the remaining-stall counter decrements.
  - The FSM returns to RUN on the cycle the counter reaches 0.
- **mem_busy=1 in any state:**
  - All enables are 0 and redirect=0.
  - Valids, counters and the remaining-stall counter hold.
  - At the clock edge the FSM enters FREEZE and records the state it left (RUN or STALL).
- **FREEZE:**
  - While mem_busy=1, outputs are as above.
  - In the first cycle with mem_busy=0, the outputs and next-state logic are those of the recorded state; hazards are re-evaluated that same cycle.
- **Counters:** wrap at 2^CNT_W and do not count FREEZE cycles.
- **rst=1:**
  - All enables are 0 and redirect=0 during the reset cycle.
  - Next cycle: state=RUN; id_valid=0 and ex_valid=0; all counters are 0.
  - rst overrides everything, including reset asserted in STALL or FREEZE.

## Timing
- Reset values: id_valid=0, ex_valid=0, state=0, stall_cnt=0, flush_cnt=0.
- Combinational outputs are 0 while rst=1.
- pc_we, if_id_we, id_ex_we, ex_mem_we and redirect are combinational from:
  - ex_instr, id_instr, branch, mem_busy;
  - state and the valid registers.
- Changes on any of those inputs take effect in the same cycle.
- Taken control transfer: redirect lasts 1 cycle and is followed by exactly 2 bubbles (ID and EX invalid).
- Load-use: exactly LU_STALL cycles with pc_we=0, excluding FREEZE cycles.
- The first fetch after reset has id_valid=1 one cycle after rst deasserts and ex_valid=1 two cycles after.

## Test plan
- **Reset:**
  - Stimulus: rst=1 for 2 cycles with arbitrary instructions.
  - During reset: all enables 0, redirect=0.
  - After release with {`ADD,4'h1,4'h2,4'h3} in both stages: enables=1; id_valid=1 one cycle later; ex_valid=1 two cycles later; counters=0.
- **Load-use, LU_STALL=1:**
  - Stimulus: ex {`LW,4'h3,8'h10} and id {`ADD,4'h1,4'h3,4'h2}, both valid.
  - Response: one cycle of pc_we=0 and if_id_we=0; ex_valid=0 next cycle; stall_cnt=1.
  - Negative case: id {`ADD,4'h1,4'h4,4'h5} produces no stall.
- **Taken branch:**
  - Stimulus: ex {`B,4'h0,8'h05} with branch=1.
  - Response: redirect=1 for one cycle; both valids 0 next cycle; flush_cnt=1.
  - Same instruction with branch=0: redirect=0 and flush_cnt unchanged.
- **CALL and RET:**
  - Stimulus: ex {`CALL,12'h000}, then {`RET,12'h000}, with branch=0.
  - Response: redirect=1 for each; flush_cnt=2.
  - Same instructions with ex_valid=0: no redirect.
- **Freeze during STALL, LU_STALL=3:**
  - Stimulus: assert mem_busy for 3 cycles after the first stall cycle.
  - Response: all enables 0, state=2, stall counter held.
  - After release: 2 more stall cycles, then RUN; stall_cnt=3.
- **Reset mid-stall:**
  - Stimulus: rst=1 in STALL.
  - Response: next cycle state=0, valids 0, stall_cnt=0; no residual stall after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: sequencing controller for the 16-bit five-stage core.
// Owns the IF/ID and ID/EX valid bits, drives the pipeline register write
// enables, inserts load-use bubbles, freezes on data-memory busy and flushes
// the two younger stages when a control transfer reaches EX.
module pipe_hazard_ctrl #(
  parameter int unsigned LU_STALL = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      id_instr,
  input  logic [15:0]      ex_instr,
  input  logic             branch,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             redirect,
  output logic             id_valid,
  output logic             ex_valid,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_NAND = 4'h2;
  localparam logic [3:0] OP_XOR  = 4'h3;
  localparam logic [3:0] OP_INC  = 4'h4;
  localparam logic [3:0] OP_SRA  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_LW   = 4'h9;
  localparam logic [3:0] OP_LHB  = 4'hA;
  localparam logic [3:0] OP_LLB  = 4'hB;
  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;

  // Remaining-stall reload after the first load-use bubble (LU_STALL <= 3).
  localparam logic [1:0] LU_RELOAD = 2'(LU_STALL - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  state_t           ret_state_q, ret_state_d;
  state_t           eff_state;
  logic [1:0]       rem_q, rem_d;
  logic             id_valid_q, id_valid_d;
  logic             ex_valid_q, ex_valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             src_hit;
  logic             lu_haz;
  logic             ctl_haz;
  logic [3:0]       ld_dst;

  assign ld_dst = ex_instr[11:8];

  // Does the ID instruction read the register the EX load writes?
  always_comb begin
    src_hit = 1'b0;
    unique case (id_instr[15:12])
      OP_ADD, OP_SUB, OP_NAND, OP_XOR:
        src_hit = (id_instr[7:4] == ld_dst) || (id_instr[3:0] == ld_dst);
      OP_SRA, OP_SRL, OP_SLL:
        src_hit = (id_instr[7:4] == ld_dst);
      OP_INC, OP_SW, OP_LHB, OP_LLB:
        src_hit = (id_instr[11:8] == ld_dst);
      OP_RET:
        src_hit = (ld_dst == 4'hF);
      default:
        src_hit = 1'b0;
    endcase
  end

  assign lu_haz  = ex_valid_q && id_valid_q && (ex_instr[15:12] == OP_LW) && src_hit;
  assign ctl_haz = ex_valid_q && (((ex_instr[15:12] == OP_B) && branch) ||
                                  (ex_instr[15:12] == OP_CALL) ||
                                  (ex_instr[15:12] == OP_RET));

  // Leaving FREEZE behaves exactly like the state that was frozen.
  assign eff_state = (state_q == FREEZE) ? ret_state_q : state_q;

  // Enables and next-state selection, priority rst > busy > ctl > lu > normal.
  always_comb begin
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    id_ex_we    = 1'b0;
    ex_mem_we   = 1'b0;
    redirect    = 1'b0;
    state_d     = state_q;
    ret_state_d = ret_state_q;
    rem_d       = rem_q;
    id_valid_d  = id_valid_q;
    ex_valid_d  = ex_valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (rst) begin
      // Registers are cleared in the sequential block; outputs stay low.
    end else if (mem_busy) begin
      state_d     = FREEZE;
      ret_state_d = eff_state;
    end else if (eff_state == STALL) begin
      id_ex_we    = 1'b1;
      ex_mem_we   = 1'b1;
      ex_valid_d  = 1'b0;
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
      rem_d       = rem_q - 2'd1;
      state_d     = (rem_d == 2'd0) ? RUN : STALL;
    end else if (ctl_haz) begin
      pc_we       = 1'b1;
      if_id_we    = 1'b1;
      id_ex_we    = 1'b1;
      ex_mem_we   = 1'b1;
      redirect    = 1'b1;
      id_valid_d  = 1'b0;
      ex_valid_d  = 1'b0;
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
      state_d     = RUN;
    end else if (lu_haz) begin
      id_ex_we    = 1'b1;
      ex_mem_we   = 1'b1;
      ex_valid_d  = 1'b0;
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (LU_STALL > 1) begin
        rem_d   = LU_RELOAD;
        state_d = STALL;
      end else begin
        state_d = RUN;
      end
    end else begin
      pc_we      = 1'b1;
      if_id_we   = 1'b1;
      id_ex_we   = 1'b1;
      ex_mem_we  = 1'b1;
      id_valid_d = 1'b1;
      ex_valid_d = id_valid_q;
      state_d    = RUN;
    end
  end

  // State, valid and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      ret_state_q <= RUN;
      rem_q       <= '0;
      id_valid_q  <= 1'b0;
      ex_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
      rem_q       <= rem_d;
      id_valid_q  <= id_valid_d;
      ex_valid_q  <= ex_valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign id_valid  = id_valid_q;
  assign ex_valid  = ex_valid_q;
  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LU_STALL=1/CNT_W=16 and
// LU_STALL=3/CNT_W=4) share stimulus and are compared against a
// cycle-level reference model of the sequencing rules.
module tb_pipe_hazard_ctrl;

  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, NAND = 4'h2, XOR = 4'h3,
                         INC = 4'h4, SRA = 4'h5, SRL = 4'h6, SLL = 4'h7,
                         SW = 4'h8, LW = 4'h9, LHB = 4'hA, LLB = 4'hB,
                         BR = 4'hC, CALL = 4'hD, RET = 4'hE;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] id_instr = '0;
  logic [15:0] ex_instr = '0;
  logic        branch = 1'b0;
  logic        mem_busy = 1'b0;

  logic       pc_we1, if_id_we1, id_ex_we1, ex_mem_we1, redirect1, id_valid1, ex_valid1;
  logic [1:0] state1;
  logic [15:0] stall_cnt1, flush_cnt1;
  logic       pc_we3, if_id_we3, id_ex_we3, ex_mem_we3, redirect3, id_valid3, ex_valid3;
  logic [1:0] state3;
  logic [3:0] stall_cnt3, flush_cnt3;

  pipe_hazard_ctrl #(.LU_STALL(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .id_instr(id_instr), .ex_instr(ex_instr),
    .branch(branch), .mem_busy(mem_busy), .pc_we(pc_we1), .if_id_we(if_id_we1),
    .id_ex_we(id_ex_we1), .ex_mem_we(ex_mem_we1), .redirect(redirect1),
    .id_valid(id_valid1), .ex_valid(ex_valid1), .state(state1),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1));

  pipe_hazard_ctrl #(.LU_STALL(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .id_instr(id_instr), .ex_instr(ex_instr),
    .branch(branch), .mem_busy(mem_busy), .pc_we(pc_we3), .if_id_we(if_id_we3),
    .id_ex_we(id_ex_we3), .ex_mem_we(ex_mem_we3), .redirect(redirect3),
    .id_valid(id_valid3), .ex_valid(ex_valid3), .state(state3),
    .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3));

  always #5 clk = ~clk;

  logic [4:0]  o_en[2];
  logic [31:0] o_reg[2];
  logic [31:0] o_sc[2];
  logic [31:0] o_fc[2];
  assign o_en[0]  = {pc_we1, if_id_we1, id_ex_we1, ex_mem_we1, redirect1};
  assign o_en[1]  = {pc_we3, if_id_we3, id_ex_we3, ex_mem_we3, redirect3};
  assign o_reg[0] = {28'd0, id_valid1, ex_valid1, state1};
  assign o_reg[1] = {28'd0, id_valid3, ex_valid3, state3};
  assign o_sc[0]  = {16'd0, stall_cnt1};
  assign o_sc[1]  = {28'd0, stall_cnt3};
  assign o_fc[0]  = {16'd0, flush_cnt1};
  assign o_fc[1]  = {28'd0, flush_cnt3};

  int checks = 0;
  int failures = 0;

  // Reference model: pending stall count rather than an explicit FSM.
  bit m_id[2], m_ex[2], m_frz[2];
  int m_rem[2], m_sc[2], m_fc[2];
  bit known = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Set of registers (bitmask) an instruction reads in ID.
  function automatic logic [15:0] reads(input logic [15:0] ins);
    logic [15:0] m;
    m = '0;
    case (ins[15:12])
      ADD, SUB, NAND, XOR: begin m[ins[7:4]] = 1'b1; m[ins[3:0]] = 1'b1; end
      SRA, SRL, SLL:       m[ins[7:4]] = 1'b1;
      INC, SW, LHB, LLB:   m[ins[11:8]] = 1'b1;
      RET:                 m[15] = 1'b1;
      default:             m = '0;
    endcase
    return m;
  endfunction

  task automatic cycle(input logic r, input logic [15:0] idi, input logic [15:0] exi,
                       input logic br, input logic bsy);
    @(negedge clk);
    rst = r; id_instr = idi; ex_instr = exi; branch = br; mem_busy = bsy;
    #1;
    for (int k = 0; k < 2; k++) begin
      int lu_len;
      int mask;
      logic [4:0] en;
      logic [15:0] rd;
      bit ctl, lu;
      lu_len = (k == 0) ? 1 : 3;
      mask   = (k == 0) ? 32'hFFFF : 32'hF;
      if (known) begin
        chk($sformatf("regs%0d", k), o_reg[k],
            {28'd0, m_id[k], m_ex[k], (m_frz[k] ? 2'd2 : (m_rem[k] > 0 ? 2'd1 : 2'd0))});
        chk($sformatf("stall_cnt%0d", k), o_sc[k], m_sc[k] & mask);
        chk($sformatf("flush_cnt%0d", k), o_fc[k], m_fc[k] & mask);
      end
      rd  = reads(idi);
      ctl = m_ex[k] && ((exi[15:12] == BR && br) || exi[15:12] == CALL || exi[15:12] == RET);
      lu  = m_ex[k] && m_id[k] && exi[15:12] == LW && rd[exi[11:8]];
      if (r) begin
        en = 5'b00000;
        m_id[k] = 0; m_ex[k] = 0; m_frz[k] = 0; m_rem[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      end else if (bsy) begin
        en = 5'b00000;
        m_frz[k] = 1;
      end else begin
        m_frz[k] = 0;
        if (m_rem[k] > 0) begin
          en = 5'b00110; m_ex[k] = 0; m_sc[k]++; m_rem[k]--;
        end else if (ctl) begin
          en = 5'b11111; m_id[k] = 0; m_ex[k] = 0; m_fc[k]++;
        end else if (lu) begin
          en = 5'b00110; m_ex[k] = 0; m_sc[k]++; m_rem[k] = lu_len - 1;
        end else begin
          en = 5'b11110; m_ex[k] = m_id[k]; m_id[k] = 1;
        end
      end
      chk($sformatf("enables%0d", k), {27'd0, o_en[k]}, {27'd0, en});
    end
    if (r) known = 1;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] op;
    logic [3:0] f[3];
    op = ($urandom_range(0, 3) == 0) ? LW : 4'($urandom_range(0, 15));
    for (int i = 0; i < 3; i++) begin
      f[i] = 4'($urandom_range(0, 4));
      if (f[i] == 4'd4) f[i] = 4'hF;
    end
    return {op, f[0], f[1], f[2]};
  endfunction

  logic [15:0] add123, lw3, add_dep, add_nodep, b5, callz, retz;

  initial begin
    add123    = {ADD, 4'h1, 4'h2, 4'h3};
    lw3       = {LW, 4'h3, 8'h10};
    add_dep   = {ADD, 4'h1, 4'h3, 4'h2};
    add_nodep = {ADD, 4'h1, 4'h4, 4'h5};
    b5        = {BR, 4'h0, 8'h05};
    callz     = {CALL, 12'h000};
    retz      = {RET, 12'h000};

    // Reset, then fill the pipe.
    cycle(1, 16'h9abc, 16'h1234, 1, 0);
    cycle(1, add123, add123, 0, 0);
    repeat (3) cycle(0, add123, add123, 0, 0);
    // Load-use hit, then non-dependent case.
    cycle(0, add_dep, lw3, 0, 0);
    repeat (4) cycle(0, add123, add123, 0, 0);
    cycle(0, add_nodep, lw3, 0, 0);
    repeat (2) cycle(0, add123, add123, 0, 0);
    // Branch taken / not taken, CALL, RET, and with ex invalid after flush.
    cycle(0, add123, b5, 1, 0);
    cycle(0, add123, callz, 0, 0);
    repeat (2) cycle(0, add123, add123, 0, 0);
    cycle(0, add123, b5, 0, 0);
    cycle(0, add123, callz, 0, 0);
    repeat (2) cycle(0, add123, add123, 0, 0);
    cycle(0, add123, retz, 0, 0);
    repeat (2) cycle(0, add123, add123, 0, 0);
    // Freeze after the first stall cycle.
    cycle(0, add_dep, lw3, 0, 0);
    repeat (3) cycle(0, add_dep, lw3, 0, 1);
    repeat (4) cycle(0, add_dep, add123, 0, 0);
    // Reset in the middle of a stall.
    repeat (2) cycle(0, add123, add123, 0, 0);
    cycle(0, add_dep, lw3, 0, 0);
    cycle(1, add_dep, lw3, 0, 0);
    repeat (4) cycle(0, add123, add123, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0, rand_instr(), rand_instr(),
            1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
    end
    cycle(0, add123, add123, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
